uart_led_ctrl: RTL and testbench

//  Multi-channel LED controller commanded over UART. Consumes the byte stream from

---
 rtl/uart_led_pkg.sv | 29 ++
 rtl/led_pwm_chan.sv | 55 +++++
 rtl/uart_led_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_uart_led_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_led_pkg.sv
// Shared definitions for the UART-commanded LED controller.
// Holds the channel mode encodings, the frame header and broadcast byte values,
// the parser state encoding and the frame checksum helper.
package uart_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_ON     = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_BREATH = 2'd3
    } mode_e;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] BCAST_CH = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StGetCh,
        StGetMode,
        StGetLvl,
        StGetCsum
    } parse_state_e;

    function automatic logic [7:0] frame_csum(input logic [7:0] ch, input logic [7:0] mode,
                                              input logic [7:0] lvl);
        return ch ^ mode ^ lvl;
    endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: turns mode + level into a PWM duty and drives a registered LED bit.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_mode            channel mode (off/on/blink/breath)
//   i_level           mapped brightness level
//   i_pwm_cnt         shared free-running PWM counter
//   i_ramp            shared triangle ramp for breathing
//   i_blink_ph        shared blink phase
//   o_led             PWM drive, 1 = lit, one cycle of latency
module led_pwm_chan
    import uart_led_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  mode_e               i_mode,
    input  logic [PWM_BITS-1:0] i_level,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic [PWM_BITS-1:0] i_ramp,
    input  logic                i_blink_ph,
    output logic                o_led
);

    localparam logic [PWM_BITS-1:0] DutyMax = '1;

    logic [2*PWM_BITS-1:0] w_breath_prod;
    logic [PWM_BITS-1:0]   w_duty;
    logic                  r_led;

    // Full-width product, then keep the top half.
    assign w_breath_prod = {{PWM_BITS{1'b0}}, i_ramp} * {{PWM_BITS{1'b0}}, i_level};

    always_comb begin
        w_duty = '0;
        unique case (i_mode)
            MODE_OFF:    w_duty = '0;
            MODE_ON:     w_duty = i_level;
            MODE_BLINK:  w_duty = i_blink_ph ? i_level : '0;
            MODE_BREATH: w_duty = w_breath_prod[2*PWM_BITS-1:PWM_BITS];
        endcase
    end

    // All-ones duty is forced lit so full brightness has no dark slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_led <= 1'b0;
        end else begin
            r_led <= (i_pwm_cnt < w_duty) || (w_duty == DutyMax);
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/uart_led_ctrl.sv
// Multi-channel LED controller commanded by 5-byte UART frames (A5, CH, MODE, LEVEL, CSUM).
// Ports:
//   i_sys_clk       single clock
//   i_sys_rst       synchronous reset, active-high
//   i_rx_data       received byte, valid with i_rx_valid
//   i_rx_valid      one-cycle strobe per received byte
//   o_led           PWM LED drive per channel, 1 = lit
//   o_active_mask   bit i set when channel i is not OFF
//   o_frm_ok        one-cycle pulse: frame accepted and applied
//   o_frm_err       one-cycle pulse: frame rejected or timed out
module uart_led_ctrl
    import uart_led_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned STEP_DIV     = 100_000,
    parameter int unsigned TIMEOUT_CLKS = 50_000
) (
    input  logic            i_sys_clk,
    input  logic            i_sys_rst,
    input  logic [7:0]      i_rx_data,
    input  logic            i_rx_valid,
    output logic [N_CH-1:0] o_led,
    output logic [N_CH-1:0] o_active_mask,
    output logic            o_frm_ok,
    output logic            o_frm_err
);

    localparam int unsigned DivW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned ToW  = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [DivW-1:0]     DivLast       = DivW'(STEP_DIV - 1);
    localparam logic [ToW-1:0]      ToLast        = ToW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]          ChLimit       = 8'(N_CH);
    localparam logic [PWM_BITS-1:0] RampBelowMax  = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [PWM_BITS-1:0] RampOne       = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] TickCntMax    = '1;

    // Parser
    parse_state_e r_state, w_state_nxt;
    logic [7:0]   r_ch_b, r_mode_b, r_lvl_b;
    logic [ToW-1:0] r_to_cnt;
    logic         w_frame_ok, w_accept, w_reject, w_timeout;
    logic         r_frm_ok, r_frm_err;

    // Channel register file
    mode_e               r_mode  [N_CH];
    logic [PWM_BITS-1:0] r_level [N_CH];

    // Shared timing
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [DivW-1:0]     r_div_cnt;
    logic                w_step_tick;
    logic [PWM_BITS-1:0] r_ramp;
    logic                r_ramp_up;
    logic [PWM_BITS-1:0] r_tick_cnt;
    logic                r_blink_ph;

    assign w_frame_ok = ((r_ch_b < ChLimit) || (r_ch_b == BCAST_CH))
                      && (r_mode_b[7:2] == 6'd0)
                      && (frame_csum(r_ch_b, r_mode_b, r_lvl_b) == i_rx_data);

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A byte arriving in the expiry cycle takes priority over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_timeout   = 1'b0;
        if (i_rx_valid) begin
            unique case (r_state)
                StIdle:    if (i_rx_data == HDR_BYTE) w_state_nxt = StGetCh;
                StGetCh:   w_state_nxt = StGetMode;
                StGetMode: w_state_nxt = StGetLvl;
                StGetLvl:  w_state_nxt = StGetCsum;
                StGetCsum: begin
                    w_state_nxt = StIdle;
                    w_accept    = w_frame_ok;
                    w_reject    = !w_frame_ok;
                end
                default:   w_state_nxt = StIdle;
            endcase
        end else if ((r_state != StIdle) && (r_to_cnt == ToLast)) begin
            w_timeout   = 1'b1;
            w_state_nxt = StIdle;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_ch_b   <= '0;
            r_mode_b <= '0;
            r_lvl_b  <= '0;
        end else if (i_rx_valid) begin
            if (r_state == StGetCh)   r_ch_b   <= i_rx_data;
            if (r_state == StGetMode) r_mode_b <= i_rx_data;
            if (r_state == StGetLvl)  r_lvl_b  <= i_rx_data;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst || i_rx_valid || (r_state == StIdle) || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_frm_ok  <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_frm_ok  <= w_accept;
            r_frm_err <= w_reject | w_timeout;
        end
    end

    // Level byte is mapped by keeping its top PWM_BITS bits.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_mode[i]  <= MODE_OFF;
                r_level[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < N_CH; i++) begin
                if ((r_ch_b == BCAST_CH) || (r_ch_b == 8'(i))) begin
                    r_mode[i]  <= mode_e'(r_mode_b[1:0]);
                    r_level[i] <= r_lvl_b[7 -: PWM_BITS];
                end
            end
        end
    end

    assign w_step_tick = (r_div_cnt == DivLast);

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_pwm_cnt <= '0;
            r_div_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_div_cnt <= w_step_tick ? '0 : r_div_cnt + 1'b1;
        end
    end

    // Triangle ramp: direction flips on the tick that lands on max or 0,
    // so each extreme lasts exactly one tick.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_ramp     <= '0;
            r_ramp_up  <= 1'b1;
            r_tick_cnt <= '0;
            r_blink_ph <= 1'b0;
        end else if (w_step_tick) begin
            if (r_ramp_up) begin
                r_ramp <= r_ramp + 1'b1;
                if (r_ramp == RampBelowMax) r_ramp_up <= 1'b0;
            end else begin
                r_ramp <= r_ramp - 1'b1;
                if (r_ramp == RampOne) r_ramp_up <= 1'b1;
            end
            r_tick_cnt <= r_tick_cnt + 1'b1;
            if (r_tick_cnt == TickCntMax) r_blink_ph <= !r_blink_ph;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        led_pwm_chan #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .i_clk      (i_sys_clk),
            .i_rst      (i_sys_rst),
            .i_mode     (r_mode[g]),
            .i_level    (r_level[g]),
            .i_pwm_cnt  (r_pwm_cnt),
            .i_ramp     (r_ramp),
            .i_blink_ph (r_blink_ph),
            .o_led      (o_led[g])
        );
        assign o_active_mask[g] = (r_mode[g] != MODE_OFF);
    end

    assign o_frm_ok  = r_frm_ok;
    assign o_frm_err = r_frm_err;

endmodule

// File: tb/tb_uart_led_ctrl.sv
// Bench for uart_led_ctrl: directed frames plus random frame traffic, every cycle
// compared against a byte-stream / arithmetic reference model.
module tb_uart_led_ctrl;

    localparam int NCh     = 4;
    localparam int PwmBits = 8;
    localparam int StepDiv = 4;
    localparam int ToClks  = 64;
    localparam int PwmSpan = 1 << PwmBits;
    localparam int RampMax = PwmSpan - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_valid = 1'b0;
    logic [NCh-1:0] led;
    logic [NCh-1:0] mask;
    logic           frm_ok;
    logic           frm_err;

    always #5 clk = ~clk;

    uart_led_ctrl #(
        .N_CH         (NCh),
        .PWM_BITS     (PwmBits),
        .STEP_DIV     (StepDiv),
        .TIMEOUT_CLKS (ToClks)
    ) dut (
        .i_sys_clk     (clk),
        .i_sys_rst     (rst),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .o_led         (led),
        .o_active_mask (mask),
        .o_frm_ok      (frm_ok),
        .o_frm_err     (frm_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int         k = 0;          // clock edges since the last reset edge
    int         m_mode [NCh];
    int         m_lvl  [NCh];
    int         m_pos = 0;      // bytes of the current frame consumed, 0 = waiting for header
    int         m_idle = 0;
    logic [7:0] fbuf [5];

    function automatic int tri_wave(input int n);
        int r;
        r = n % (2 * RampMax);
        return (r <= RampMax) ? r : (2 * RampMax - r);
    endfunction

    function automatic logic exp_led_bit(input int mode, input int lvl, input int kk);
        int n, pwm, d;
        n   = kk / StepDiv;
        pwm = kk % PwmSpan;
        case (mode)
            1:       d = lvl;
            2:       d = (((n / PwmSpan) % 2) == 1) ? lvl : 0;
            3:       d = (tri_wave(n) * lvl) >> PwmBits;
            default: d = 0;
        endcase
        return (pwm < d) || (d == RampMax);
    endfunction

    // One clock: apply what the caller drove, advance the model, compare outputs.
    task automatic step();
        logic           rs, vs;
        logic [7:0]     ds;
        int             pm [NCh];
        int             pl [NCh];
        logic           e_ok, e_err;
        logic [NCh-1:0] e_led, e_mask;
        int             ch, md, lv;
        rs = rst;
        vs = rx_valid;
        ds = rx_data;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NCh; i++) begin
            pm[i] = m_mode[i];
            pl[i] = m_lvl[i];
        end
        e_ok  = 1'b0;
        e_err = 1'b0;
        if (rs) begin
            k = 0;
            m_pos = 0;
            m_idle = 0;
            for (int i = 0; i < NCh; i++) begin
                m_mode[i] = 0;
                m_lvl[i]  = 0;
            end
        end else begin
            k++;
            if (vs) begin
                m_idle = 0;
                if (m_pos == 0) begin
                    if (ds == 8'hA5) m_pos = 1;
                end else begin
                    fbuf[m_pos] = ds;
                    m_pos++;
                    if (m_pos == 5) begin
                        m_pos = 0;
                        ch = int'(fbuf[1]);
                        md = int'(fbuf[2]);
                        lv = int'(fbuf[3]);
                        if ((ch < NCh || ch == 255) && md <= 3
                            && (fbuf[1] ^ fbuf[2] ^ fbuf[3]) == fbuf[4]) begin
                            e_ok = 1'b1;
                            for (int i = 0; i < NCh; i++) begin
                                if (ch == 255 || ch == i) begin
                                    m_mode[i] = md;
                                    m_lvl[i]  = lv >> (8 - PwmBits);
                                end
                            end
                        end else begin
                            e_err = 1'b1;
                        end
                    end
                end
            end else if (m_pos != 0) begin
                m_idle++;
                if (m_idle == ToClks) begin
                    e_err  = 1'b1;
                    m_pos  = 0;
                    m_idle = 0;
                end
            end
        end
        for (int i = 0; i < NCh; i++) begin
            e_led[i]  = rs ? 1'b0 : exp_led_bit(pm[i], pl[i], k - 1);
            e_mask[i] = (m_mode[i] != 0);
        end
        check_eq("led", 32'(led), 32'(e_led));
        check_eq("flags{ok,err,mask}", 32'({frm_ok, frm_err, mask}), 32'({e_ok, e_err, e_mask}));
        rx_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
    endtask

    task automatic send_raw(input logic [7:0] ch, input logic [7:0] md, input logic [7:0] lv,
                            input logic [7:0] cs, input int gmax);
        send_byte(8'hA5);
        gap($urandom_range(0, gmax));
        send_byte(ch);
        gap($urandom_range(0, gmax));
        send_byte(md);
        gap($urandom_range(0, gmax));
        send_byte(lv);
        gap($urandom_range(0, gmax));
        send_byte(cs);
    endtask

    task automatic send_frame(input logic [7:0] ch, input logic [7:0] md, input logic [7:0] lv,
                              input int gmax);
        send_raw(ch, md, lv, ch ^ md ^ lv, gmax);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int         cnt;
    logic [7:0] r_ch, r_md, r_lv, r_b;

    initial begin
        do_reset();
        gap(3);

        // Channel 1 fully on
        send_frame(8'h01, 8'h01, 8'hFF, 0);
        gap(3);
        check_eq("t1_mask", 32'(mask), 32'h2);
        check_eq("t1_led", 32'(led), 32'h2);

        // Half duty on channel 0
        do_reset();
        send_frame(8'h00, 8'h01, 8'h80, 0);
        gap(2);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (led[0]) cnt++;
        end
        check_eq("t2_duty", 32'(cnt), 32'd128);

        // Broadcast breath: all channels stay in lockstep over a full ramp period
        do_reset();
        send_frame(8'hFF, 8'h03, 8'hFF, 0);
        cnt = 0;
        for (int i = 0; i < 2 * RampMax * StepDiv + 40; i++) begin
            step();
            if (led != '0 && led != '1) cnt++;
        end
        check_eq("t3_lockstep", 32'(cnt), 32'd0);

        // Error frames leave the registers alone
        do_reset();
        send_frame(8'h02, 8'h02, 8'h40, 1);
        gap(2);
        cnt = 0;
        send_raw(8'h00, 8'h01, 8'h10, 8'h00, 0);
        if (frm_err) cnt++;
        send_raw(8'h07, 8'h01, 8'h10, 8'h16, 0);
        if (frm_err) cnt++;
        send_raw(8'h00, 8'h05, 8'h10, 8'h15, 0);
        if (frm_err) cnt++;
        gap(2);
        check_eq("t4_err_count", 32'(cnt), 32'd3);
        check_eq("t4_mask", 32'(mask), 32'h4);

        // Timeout after a partial frame, then a normal frame
        send_byte(8'hA5);
        send_byte(8'h00);
        cnt = 0;
        for (int i = 0; i < ToClks + 5; i++) begin
            step();
            if (frm_err) cnt++;
        end
        check_eq("t5_timeout_pulses", 32'(cnt), 32'd1);
        send_frame(8'h00, 8'h02, 8'hC0, 2);
        check_eq("t5_ok_after", 32'(frm_ok), 32'd1);

        // Reset after the MODE byte; trailing bytes must be ignored
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        send_byte(8'h80);
        send_byte(8'h82);
        gap(3);
        check_eq("t6_mask", 32'(mask), 32'h0);
        check_eq("t6_led", 32'(led), 32'h0);

        // Random traffic
        for (int f = 0; f < 250; f++) begin
            r_md = 8'($urandom_range(0, 3));
            r_lv = 8'($urandom_range(0, 255));
            r_ch = ($urandom_range(0, 4) == 4) ? 8'hFF : 8'($urandom_range(0, NCh - 1));
            case ($urandom_range(0, 10))
                0, 1, 2, 3, 4, 5: send_frame(r_ch, r_md, r_lv, 5);
                6: send_raw(r_ch, r_md, r_lv, r_ch ^ r_md ^ r_lv ^ 8'($urandom_range(1, 255)), 5);
                7: send_frame(8'($urandom_range(NCh, 254)), r_md, r_lv, 5);
                8: send_frame(r_ch, 8'($urandom_range(4, 255)), r_lv, 5);
                9: begin
                    r_b = 8'($urandom_range(0, 255));
                    if (r_b == 8'hA5) r_b = 8'h00;
                    send_byte(r_b);
                end
                default: begin
                    send_byte(8'hA5);
                    send_byte(r_ch);
                    gap(ToClks + 3);
                end
            endcase
            gap($urandom_range(0, 60));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
